// File: rtl/halfstrip_checker_pkg.sv
// Shared types and defaults for the half-strip comparison checker.
package halfstrip_checker_pkg;

  localparam int NHS_DEF     = 32;
  localparam int CNT_W_DEF   = 32;
  localparam int TRIAL_W_DEF = 16;
  localparam int WIN_W       = 4;

  // Trial sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DELAY   = 3'd1,
    ST_ACCUM   = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/halfstrip_checker_sat_counter.sv
// Saturating up-counter: holds at all-ones, clear has priority over increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear first, otherwise increment unless already full.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/halfstrip_checker.sv
// Half-strip pulse checker: after each fire strobe, ORs the decoder hits over
// a delayed window, compares against the expected pattern and keeps
// saturating trial / mismatch counters.
//
// Handshake: fire is a single-cycle request accepted only while busy is low;
// a fire seen while busy is high (including the done cycle) is dropped and
// recorded in the sticky fire_missed flag. done is a single-cycle strobe in
// which match and hs_latched hold the result of the trial just finished.
module halfstrip_checker
  import halfstrip_checker_pkg::*;
#(
  parameter int NHS     = NHS_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TRIAL_W = TRIAL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fire,
  input  logic [WIN_W-1:0]   win_delay,
  input  logic [WIN_W-1:0]   win_len,
  input  logic [NHS-1:0]     halfstrips,
  input  logic [NHS-1:0]     halfstrips_expect,
  input  logic               errcnt_rst,
  output logic               busy,
  output logic               done,
  output logic               match,
  output logic [NHS-1:0]     hs_latched,
  output logic [CNT_W-1:0]   halfstrips_errcnt,
  output logic [TRIAL_W-1:0] trials,
  output logic               fire_missed,
  output state_e             state_dbg
);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] dly_q, dly_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [NHS-1:0]   acc_q, acc_d;
  logic [NHS-1:0]   hs_latched_q, hs_latched_d;
  logic             match_q, match_d;
  logic             fire_missed_q, fire_missed_d;
  logic             trial_inc;
  logic             err_inc;

  // Sequencer next-state and datapath updates.
  always_comb begin
    state_d       = state_q;
    dly_d         = dly_q;
    len_d         = len_q;
    acc_d         = acc_q;
    hs_latched_d  = hs_latched_q;
    match_d       = match_q;
    trial_inc     = 1'b0;
    err_inc       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fire) begin
          // Window parameters are captured here and ignored for the rest of the trial.
          dly_d   = win_delay;
          len_d   = win_len;
          acc_d   = '0;
          state_d = (win_delay == '0) ? ST_ACCUM : ST_DELAY;
        end
      end
      ST_DELAY: begin
        // Entered with dly >= 1; leave after exactly win_delay cycles here.
        if (dly_q == WIN_W'(1)) begin
          state_d = ST_ACCUM;
        end else begin
          dly_d = dly_q - WIN_W'(1);
        end
      end
      ST_ACCUM: begin
        acc_d = acc_q | halfstrips;
        if (len_q == '0) begin
          state_d = ST_COMPARE;
        end else begin
          len_d = len_q - WIN_W'(1);
        end
      end
      ST_COMPARE: begin
        hs_latched_d = acc_q;
        match_d      = (acc_q == halfstrips_expect);
        trial_inc    = 1'b1;
        err_inc      = (acc_q != halfstrips_expect);
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky missed-fire flag; a counter clear in the same cycle wins.
  always_comb begin
    fire_missed_d = fire_missed_q;
    if (errcnt_rst) begin
      fire_missed_d = 1'b0;
    end else if (fire && (state_q != ST_IDLE)) begin
      fire_missed_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      dly_q         <= '0;
      len_q         <= '0;
      acc_q         <= '0;
      hs_latched_q  <= '0;
      match_q       <= 1'b0;
      fire_missed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dly_q         <= dly_d;
      len_q         <= len_d;
      acc_q         <= acc_d;
      hs_latched_q  <= hs_latched_d;
      match_q       <= match_d;
      fire_missed_q <= fire_missed_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_errcnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (errcnt_rst),
    .q     (halfstrips_errcnt)
  );

  sat_counter #(.WIDTH(TRIAL_W)) u_trials (
    .clk   (clk),
    .reset (reset),
    .inc   (trial_inc),
    .clr   (errcnt_rst),
    .q     (trials)
  );

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign match       = match_q;
  assign hs_latched  = hs_latched_q;
  assign fire_missed = fire_missed_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_halfstrip_checker.sv
// Bench for halfstrip_checker: directed trials with literal expectations plus
// a randomized run, all compared every cycle against a trial-level model.
module tb_halfstrip_checker;
  import halfstrip_checker_pkg::*;

  localparam int NHS     = 32;
  localparam int CNT_W   = 4;
  localparam int TRIAL_W = 5;
  localparam int ERR_MAX = (1 << CNT_W) - 1;
  localparam int TRI_MAX = (1 << TRIAL_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               reset_i;
  logic               fire_i;
  logic [3:0]         wd_i;
  logic [3:0]         wl_i;
  logic [NHS-1:0]     hs_i;
  logic [NHS-1:0]     exp_i;
  logic               errrst_i;
  logic               busy;
  logic               done;
  logic               match;
  logic [NHS-1:0]     hs_latched;
  logic [CNT_W-1:0]   errcnt;
  logic [TRIAL_W-1:0] trials;
  logic               fire_missed;
  state_e             state_dbg;

  always #5 clk = ~clk;

  halfstrip_checker #(.NHS(NHS), .CNT_W(CNT_W), .TRIAL_W(TRIAL_W)) dut (
    .clk               (clk),
    .reset             (reset_i),
    .fire              (fire_i),
    .win_delay         (wd_i),
    .win_len           (wl_i),
    .halfstrips        (hs_i),
    .halfstrips_expect (exp_i),
    .errcnt_rst        (errrst_i),
    .busy              (busy),
    .done              (done),
    .match             (match),
    .hs_latched        (hs_latched),
    .halfstrips_errcnt (errcnt),
    .trials            (trials),
    .fire_missed       (fire_missed),
    .state_dbg         (state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
  endtask

  // ---------------- trial-level reference model ----------------
  // A trial started at cycle t with delay d and length l samples hits in
  // cycles t+d+1 .. t+d+l+1, compares at t+d+l+2, and shows done at t+d+l+3.
  int          cyc = 0;
  bit          m_active;
  int          m_t, m_d, m_l;
  logic [31:0] m_acc, m_lat;
  bit          m_match, m_missed;
  int          m_err, m_trials;

  task automatic model_update();
    bit busy_now;
    if (reset_i) begin
      m_active = 0; m_acc = '0; m_lat = '0; m_match = 0;
      m_err = 0; m_trials = 0; m_missed = 0;
    end else begin
      busy_now = m_active;
      if (m_active && cyc >= m_t + m_d + 1 && cyc <= m_t + m_d + m_l + 1)
        m_acc = m_acc | hs_i;
      if (m_active && cyc == m_t + m_d + m_l + 2) begin
        m_lat   = m_acc;
        m_match = (m_acc == exp_i);
        if (!errrst_i) begin
          if (m_trials < TRI_MAX) m_trials++;
          if (!m_match && m_err < ERR_MAX) m_err++;
        end
      end
      if (errrst_i) begin
        m_err = 0; m_trials = 0; m_missed = 0;
      end else if (fire_i && busy_now) begin
        m_missed = 1;
      end
      if (m_active && cyc == m_t + m_d + m_l + 3) m_active = 0;
      if (fire_i && !busy_now) begin
        m_active = 1; m_t = cyc; m_d = int'(wd_i); m_l = int'(wl_i); m_acc = '0;
      end
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic compare_outputs();
    bit m_done;
    m_done = m_active && (cyc == m_t + m_d + m_l + 3);
    chk("busy",        32'(busy),        32'(m_active));
    chk("done",        32'(done),        32'(m_done));
    chk("match",       32'(match),       32'(m_match));
    chk("hs_latched",  hs_latched,       m_lat);
    chk("errcnt",      32'(errcnt),      32'(m_err));
    chk("trials",      32'(trials),      32'(m_trials));
    chk("fire_missed", 32'(fire_missed), 32'(m_missed));
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_strobes();
    fire_i = 0; reset_i = 0; errrst_i = 0; hs_i = '0;
  endtask

  // Inputs already applied for this cycle: update model, advance, compare.
  task automatic cycle();
    model_update();
    @(negedge clk);
    cyc++;
    compare_outputs();
    clear_strobes();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // One full trial, ending in the idle cycle after done.
  task automatic run_trial(input int d, input int l, input logic [31:0] hs_pat,
                           input logic [31:0] exp_pat);
    for (int k = 0; k < d + l + 4; k++) begin
      fire_i = (k == 0);
      wd_i   = 4'(d);
      wl_i   = 4'(l);
      exp_i  = exp_pat;
      hs_i   = (k >= d + 1 && k <= d + l + 1) ? hs_pat : '0;
      cycle();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_strobes();
    wd_i = '0; wl_i = '0; exp_i = '0;
    m_active = 0; m_t = 0; m_d = 0; m_l = 0; m_acc = '0; m_lat = '0;
    m_match = 0; m_missed = 0; m_err = 0; m_trials = 0;

    // Reset state.
    reset_i = 1; model_update();
    @(negedge clk); cyc++;
    reset_i = 1; cycle();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_errcnt", 32'(errcnt), 0);
    chk("rst_hs_latched", hs_latched, 0);
    idle_cycles(2);

    // 1 Match, delay 0 / len 0: done at T+3.
    for (int k = 0; k < 3; k++) begin
      fire_i = (k == 0); wd_i = 0; wl_i = 0;
      hs_i = (k == 1) ? 32'h10 : '0; exp_i = 32'h10;
      cycle();
    end
    chk("t1_done", 32'(done), 1);
    chk("t1_match", 32'(match), 1);
    chk("t1_hs_latched", hs_latched, 32'h10);
    chk("t1_trials", 32'(trials), 1);
    chk("t1_errcnt", 32'(errcnt), 0);
    idle_cycles(1);

    // 2 Window OR, delay 2 / len 3: hit at T+7 falls outside, done at T+8.
    for (int k = 0; k < 8; k++) begin
      fire_i = (k == 0); wd_i = 2; wl_i = 3; exp_i = 32'h101;
      hs_i = (k == 3) ? 32'h1 : (k == 6) ? 32'h100 : (k == 7) ? 32'h8000 : '0;
      cycle();
    end
    chk("t2_done", 32'(done), 1);
    chk("t2_hs_latched", hs_latched, 32'h101);
    chk("t2_match", 32'(match), 1);
    idle_cycles(1);

    // 3 Mismatch: five trials.
    errrst_i = 1; cycle();
    for (int i = 0; i < 5; i++) run_trial(0, 0, 32'h0, 32'hFFFF_0000);
    chk("t3_match", 32'(match), 0);
    chk("t3_errcnt", 32'(errcnt), 5);
    chk("t3_trials", 32'(trials), 5);

    // 4 Overlap: fires during ACCUM (T+2) and DONE (T+6) are dropped.
    for (int k = 0; k < 7; k++) begin
      fire_i = (k == 0 || k == 2 || k == 6); wd_i = 0; wl_i = 3; exp_i = '0;
      cycle();
    end
    chk("t4_busy", 32'(busy), 0);
    chk("t4_trials", 32'(trials), 6);
    chk("t4_fire_missed", 32'(fire_missed), 1);
    errrst_i = 1; cycle();
    chk("t4_missed_clr", 32'(fire_missed), 0);

    // 5 Saturation and clear priority.
    for (int i = 0; i < 17; i++) run_trial(0, 0, 32'h0, 32'h1);
    chk("t5_err_sat", 32'(errcnt), ERR_MAX);
    chk("t5_trials", 32'(trials), 17);
    for (int k = 0; k < 3; k++) begin
      fire_i = (k == 0); wd_i = 0; wl_i = 0; exp_i = 32'h5;
      hs_i = (k == 1) ? 32'h5 : '0;
      errrst_i = (k == 2);
      cycle();
    end
    chk("t5_clr_err", 32'(errcnt), 0);
    chk("t5_clr_trials", 32'(trials), 0);
    chk("t5_clr_match", 32'(match), 1);
    chk("t5_clr_hs", hs_latched, 32'h5);
    idle_cycles(1);
    for (int i = 0; i < 33; i++) run_trial(0, 0, 32'h3, 32'h3);
    chk("t5_trials_sat", 32'(trials), TRI_MAX);

    // 6 Reset during DELAY, then a normal trial.
    for (int k = 0; k < 3; k++) begin
      fire_i = (k == 0); wd_i = 5; wl_i = 0;
      reset_i = (k == 2);
      cycle();
    end
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_trials", 32'(trials), 0);
    chk("t6_match", 32'(match), 0);
    idle_cycles(8);
    run_trial(1, 2, 32'h40, 32'h40);
    chk("t6_after_trials", 32'(trials), 1);
    chk("t6_after_match", 32'(match), 1);

    // Randomized run.
    for (int i = 0; i < 4000; i++) begin
      fire_i   = ($urandom_range(0, 3) == 0);
      wd_i     = 4'($urandom_range(0, 15));
      wl_i     = 4'($urandom_range(0, 15));
      hs_i     = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
      exp_i    = ($urandom_range(0, 1) == 0) ? '0 : (32'h1 << $urandom_range(0, 31));
      errrst_i = ($urandom_range(0, 63) == 0);
      reset_i  = ($urandom_range(0, 499) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
